// File: rtl/alu_sched.sv
// Two-requester round-robin scheduler in front of a shared combinational ALU.
// Optional condition-code register is enabled by defining ALU_SCHED_CC_EN.
`timescale 1ns/1ps
module alu_sched #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_setcc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_setcc,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_ovf,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_ovf,
    output logic             rsp_zero,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_res_q, rsp_res_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             grant;
    logic             ready0;
    logic             ready1;

`ifdef ALU_SCHED_CC_EN
    logic setcc_q, setcc_d;
    logic cc_zf_q, cc_zf_d;
    logic cc_sf_q, cc_sf_d;
    logic cc_of_q, cc_of_d;
`else
    logic unused_setcc;
    assign unused_setcc = req0_setcc ^ req1_setcc;
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_res_d   = rsp_res_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_zero_d  = rsp_zero_q;
`ifdef ALU_SCHED_CC_EN
        setcc_d     = setcc_q;
        cc_zf_d     = cc_zf_q;
        cc_sf_d     = cc_sf_q;
        cc_of_d     = cc_of_q;
`endif
        ready0      = 1'b0;
        ready1      = 1'b1 & 1'b0;
        // With both valid the requester not served last wins; last_q resets to 1 so req0 leads.
        grant       = (req0_valid && req1_valid) ? ~last_q : req1_valid;

        case (state_q)
            IDLE: begin
                ready0 = req0_valid && !grant;
                ready1 = req1_valid && grant;
                if (ready0 || ready1) begin
                    op_d    = grant ? req1_op : req0_op;
                    a_d     = grant ? req1_a  : req0_a;
                    b_d     = grant ? req1_b  : req0_b;
`ifdef ALU_SCHED_CC_EN
                    setcc_d = grant ? req1_setcc : req0_setcc;
`endif
                    id_d    = grant;
                    last_d  = grant;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_res_d   = alu_res;
                rsp_ovf_d   = alu_ovf;
                rsp_zero_d  = alu_zero;
                rsp_valid_d = 1'b1;
`ifdef ALU_SCHED_CC_EN
                if (setcc_q) begin
                    cc_zf_d = alu_zero;
                    cc_sf_d = alu_res[WIDTH-1];
                    cc_of_d = alu_ovf;
                end
`endif
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            op_q        <= 2'b00;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_zero_q  <= 1'b0;
`ifdef ALU_SCHED_CC_EN
            setcc_q     <= 1'b0;
            cc_zf_q     <= 1'b1;
            cc_sf_q     <= 1'b0;
            cc_of_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_zero_q  <= rsp_zero_d;
`ifdef ALU_SCHED_CC_EN
            setcc_q     <= setcc_d;
            cc_zf_q     <= cc_zf_d;
            cc_sf_q     <= cc_sf_d;
            cc_of_q     <= cc_of_d;
`endif
        end
    end

    // Reset wins over any handshake in the same cycle, and the ALU only sees latched operands.
    assign req0_ready = ready0 & ~rst;
    assign req1_ready = ready1 & ~rst;
    assign alu_op     = (state_q == EXEC && !rst) ? op_q : 2'b00;
    assign alu_a      = (state_q == EXEC && !rst) ? a_q  : '0;
    assign alu_b      = (state_q == EXEC && !rst) ? b_q  : '0;

    assign rsp_valid  = rsp_valid_q & ~rst;
    assign rsp_id     = id_q;
    assign rsp_res    = rsp_res_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign rsp_zero   = rsp_zero_q;

`ifdef ALU_SCHED_CC_EN
    assign cc_zf = cc_zf_q;
    assign cc_sf = cc_sf_q;
    assign cc_of = cc_of_q;
`else
    assign cc_zf = 1'b0;
    assign cc_sf = 1'b0;
    assign cc_of = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: queued requesters, external ALU model, reference model.
`timescale 1ns/1ps
module tb_alu_sched;

    localparam int W = 64;
`ifdef ALU_SCHED_CC_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         setcc;
    } req_t;

    typedef struct {
        logic         id;
        logic [W-1:0] res;
        logic         ovf;
        logic         zero;
        logic [2:0]   cc;
        int           acc_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid [2];
    logic         req_ready [2];
    logic [1:0]   req_op    [2];
    logic [W-1:0] req_a     [2];
    logic [W-1:0] req_b     [2];
    logic         req_setcc [2];
    logic [1:0]   alu_op;
    logic [W-1:0] alu_a, alu_b, alu_res;
    logic         alu_ovf, alu_zero;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_ovf, rsp_zero;
    logic [W-1:0] rsp_res;
    logic         cc_zf, cc_sf, cc_of;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    int   acc_cnt0 = 0, acc_cnt1 = 0;
    int   pop_cnt0 = 0, pop_cnt1 = 0;
    req_t pend0 [$];
    req_t pend1 [$];
    exp_t sb [$];

    logic         last_m = 1'b1;
    logic [2:0]   cc_m = 3'b000;
    logic         prev_v = 1'b0;
    exp_t         mon_e;
    int           win, n_acc;
    logic [1:0]   expv;
    logic [W-1:0] r_m;
    logic         o_m, z_m;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_op(req_op[0]),
        .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_setcc(req_setcc[0]),
        .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_op(req_op[1]),
        .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_setcc(req_setcc[1]),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_res(alu_res), .alu_ovf(alu_ovf), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    // Shared ALU: signed overflow from operand/result sign bits.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_op)
            2'd0: begin
                alu_res = alu_a + alu_b;
                alu_ovf = (alu_a[W-1] == alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
            end
            2'd1: begin
                alu_res = alu_a - alu_b;
                alu_ovf = (alu_a[W-1] != alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
            end
            2'd2: alu_res = alu_a & alu_b;
            default: alu_res = alu_a ^ alu_b;
        endcase
        alu_zero = (alu_res == '0);
    end

    // Reference arithmetic: exact result in W+1 bits, overflow when it does not fit in W.
    function automatic void ref_alu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] r, output logic o, output logic z);
        logic [W:0] wide;
        wide = '0;
        r = '0;
        o = 1'b0;
        case (op)
            2'd0: begin wide = {a[W-1], a} + {b[W-1], b}; r = wide[W-1:0]; o = wide[W] != wide[W-1]; end
            2'd1: begin wide = {a[W-1], a} - {b[W-1], b}; r = wide[W-1:0]; o = wide[W] != wide[W-1]; end
            2'd2: r = a & b;
            default: r = a ^ b;
        endcase
        z = (r == '0);
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: flush on reset, check responses against the queue head, check grants and enqueue.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            last_m = 1'b1;
            cc_m   = CC_EN ? 3'b100 : 3'b000;
            prev_v = 1'b0;
        end else begin
            if (rsp_valid) begin
                chk("ready_in_resp", W'({req_ready[1], req_ready[0]}), '0);
                chk("alu_a_in_resp", alu_a, '0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp actual=rsp_valid=1 required=no response (t=%0t)", $time);
                end else begin
                    mon_e = sb[0];
                    chk("rsp_id", W'(rsp_id), W'(mon_e.id));
                    chk("rsp_res", rsp_res, mon_e.res);
                    chk("rsp_ovf", W'(rsp_ovf), W'(mon_e.ovf));
                    chk("rsp_zero", W'(rsp_zero), W'(mon_e.zero));
                    chk("cc_zso", W'({cc_zf, cc_sf, cc_of}), W'(mon_e.cc));
                    if (!prev_v) chk("latency", W'(cyc), W'(mon_e.acc_cyc + 2));
                    if (rsp_ready) begin
                        $display("txn id=%0d res=%h ovf=%0d zero=%0d cc=%b", rsp_id, rsp_res, rsp_ovf, rsp_zero,
                                 {cc_zf, cc_sf, cc_of});
                        void'(sb.pop_front());
                    end
                end
            end
            prev_v = rsp_valid;
            if (req_ready[0] || req_ready[1]) begin
                if (req_valid[0] && req_valid[1]) win = last_m ? 0 : 1;
                else win = req_valid[1] ? 1 : 0;
                expv = (req_valid[0] || req_valid[1]) ? (2'b01 << win) : 2'b00;
                chk("grant", W'({req_ready[1], req_ready[0]}), W'(expv));
                chk("alu_op_idle", W'(alu_op), '0);
                chk("alu_a_idle", alu_a, '0);
                n_acc = (req_ready[0] && req_valid[0]) ? 0 : 1;
                if (req_valid[n_acc] && req_ready[n_acc]) begin
                    ref_alu(req_op[n_acc], req_a[n_acc], req_b[n_acc], r_m, o_m, z_m);
                    if (CC_EN && req_setcc[n_acc]) cc_m = {z_m, r_m[W-1], o_m};
                    mon_e.id      = n_acc[0];
                    mon_e.res     = r_m;
                    mon_e.ovf     = o_m;
                    mon_e.zero    = z_m;
                    mon_e.cc      = cc_m;
                    mon_e.acc_cyc = cyc;
                    sb.push_back(mon_e);
                    last_m = n_acc[0];
                    if (n_acc == 0) acc_cnt0++;
                    else acc_cnt1++;
                end
            end
        end
    end

    // Requester drivers present queue heads; idle requesters drive junk on their data lines.
    initial begin
        for (int n = 0; n < 2; n++) begin
            req_valid[n] = 1'b0; req_op[n] = 2'b00; req_a[n] = '0; req_b[n] = '0; req_setcc[n] = 1'b0;
        end
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pop_cnt0 < acc_cnt0) begin void'(pend0.pop_front()); pop_cnt0++; end
            if (pop_cnt1 < acc_cnt1) begin void'(pend1.pop_front()); pop_cnt1++; end
            if (pend0.size() > 0) begin
                req_valid[0] = 1'b1; req_op[0] = pend0[0].op; req_a[0] = pend0[0].a;
                req_b[0] = pend0[0].b; req_setcc[0] = pend0[0].setcc;
            end else begin
                req_valid[0] = 1'b0; req_op[0] = 2'($urandom); req_a[0] = {$urandom, $urandom};
                req_b[0] = {$urandom, $urandom}; req_setcc[0] = 1'($urandom);
            end
            if (pend1.size() > 0) begin
                req_valid[1] = 1'b1; req_op[1] = pend1[0].op; req_a[1] = pend1[0].a;
                req_b[1] = pend1[0].b; req_setcc[1] = pend1[0].setcc;
            end else begin
                req_valid[1] = 1'b0; req_op[1] = 2'($urandom); req_a[1] = {$urandom, $urandom};
                req_b[1] = {$urandom, $urandom}; req_setcc[1] = 1'($urandom);
            end
            case (rdy_mode)
                0: rsp_ready = 1'b1;
                1: rsp_ready = ($urandom_range(0, 3) != 0);
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    task automatic push(input int n, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s);
        req_t r;
        r.op = op; r.a = a; r.b = b; r.setcc = s;
        if (n == 0) pend0.push_back(r);
        else pend1.push_back(r);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (k < budget && !(pend0.size() == 0 && pend1.size() == 0 && sb.size() == 0 && !rsp_valid)) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (k >= budget) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=pending(%0d,%0d,%0d) required=empty", pend0.size(), pend1.size(),
                     sb.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_any_acc(output int who);
        int k = 0;
        who = -1;
        while (who < 0 && k < 40) begin
            @(negedge clk);
            k++;
            if (req_valid[0] && req_ready[0]) who = 0;
            else if (req_valid[1] && req_ready[1]) who = 1;
        end
        if (who < 0) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=no handshake required=handshake");
        end
    endtask

    task automatic wait_rsp();
        int k = 0;
        while (!rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!rsp_valid) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout actual=rsp_valid=0 required=1");
        end
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            4: return W'($urandom_range(0, 3));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int who;
        logic [W-1:0] ra;
        rdy_mode = 0;
        rst = 1'b1;
        push(0, 2'd0, 64'd5, 64'd7, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req0_ready", W'(req_ready[0]), '0);
        chk("rst_rsp_valid", W'(rsp_valid), '0);
        chk("rst_rsp_id", W'(rsp_id), '0);
        chk("rst_rsp_res", rsp_res, '0);
        chk("rst_rsp_ovf", W'(rsp_ovf), '0);
        chk("rst_rsp_zero", W'(rsp_zero), '0);
        chk("rst_cc_zf", W'(cc_zf), W'(CC_EN));
        chk("rst_cc_sf", W'(cc_sf), '0);
        chk("rst_cc_of", W'(cc_of), '0);
        chk("rst_alu_op", W'(alu_op), '0);
        chk("rst_alu_a", alu_a, '0);
        chk("rst_alu_b", alu_b, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        drain(50);

        // Both requesters valid straight out of reset: req0 first, then req1.
        do_reset();
        push(0, 2'd1, 64'd9, 64'd9, 1'b0);
        push(1, 2'd3, 64'hF0, 64'h0F, 1'b0);
        drain(50);

        // Signed overflow into the sign bit with condition codes updated.
        push(0, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        drain(50);
        chk("ovf_cc_of", W'(cc_of), W'(CC_EN));
        chk("ovf_cc_sf", W'(cc_sf), W'(CC_EN));
        chk("ovf_cc_zf", W'(cc_zf), '0);

        // Backpressure: response held five cycles while req0 waits.
        rdy_mode = 2;
        push(1, 2'd2, 64'hFF00, 64'h0FF0, 1'b1);
        wait_rsp();
        push(0, 2'd0, 64'd1, 64'd2, 1'b0);
        repeat (5) @(negedge clk);
        rdy_mode = 0;
        @(negedge clk);
        @(negedge clk);
        chk("release_rsp_valid", W'(rsp_valid), '0);
        chk("release_req0_ready", W'(req_ready[0]), W'(1));
        drain(50);

        // Reset while req1's AND is executing: nothing comes back, req0 leads afterwards.
        do_reset();
        push(1, 2'd2, 64'd3, 64'd3, 1'b1);
        wait_any_acc(who);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("exec_rst_alu_op", W'(alu_op), '0);
        chk("exec_rst_alu_a", alu_a, '0);
        chk("exec_rst_alu_b", alu_b, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("discard_rsp_valid", W'(rsp_valid), '0);
        end
        chk("discard_cc_zf", W'(cc_zf), W'(CC_EN));
        chk("discard_cc_sf", W'(cc_sf), '0);
        chk("discard_cc_of", W'(cc_of), '0);
        push(0, 2'd0, 64'd10, 64'd20, 1'b0);
        push(1, 2'd1, 64'd10, 64'd20, 1'b1);
        wait_any_acc(who);
        chk("post_rst_grant", W'(who), '0);
        drain(50);

        // Randomized traffic with random backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 2) != 0) begin
                who = $urandom_range(0, 1);
                ra = rnd_opnd();
                if ((who == 0 ? pend0.size() : pend1.size()) < 3)
                    push(who, 2'($urandom), ra, ($urandom_range(0, 4) == 0) ? ra : rnd_opnd(), 1'($urandom));
            end
        end
        drain(600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter: WIDTH, default 64, operand/result width; SHALL match the shared ALU_64 width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid/req1_valid  input  1 each  requester N presents an operation.
REQ-005 req0_ready/req1_ready  output  1 each  scheduler accepts requester N this cycle.
REQ-006 reqN_op  input  2  ALU opcode: 00 ADD, 01 SUB, 10 AND, 11 XOR.
REQ-007 reqN_a, reqN_b  input  WIDTH  signed operands.
REQ-008 reqN_setcc  input  1  completion of this operation SHALL update condition codes.
REQ-009 alu_op  output  2; alu_a, alu_b  output  WIDTH  drive the shared ALU_64.
REQ-010 alu_res  input  WIDTH; alu_ovf, alu_zero  input  1  combinational ALU results.
REQ-011 rsp_valid  output  1; rsp_ready  input  1  result handshake.
REQ-012 rsp_id  output  1  requester that owns the result; rsp_res  output  WIDTH; rsp_ovf, rsp_zero  output  1.
REQ-013 cc_zf, cc_sf, cc_of  output  1 each  architectural condition codes.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, RESP; only IDLE SHALL assert any reqN_ready.
REQ-015 IDLE: exactly one requester is granted; reqN_ready SHALL be high only for the granted requester and only if its valid is high.
REQ-016 Arbitration SHALL be round-robin: single valid wins; both valid, the requester not served last wins; after reset req0 has priority.
REQ-017 Handshake (valid & ready) SHALL latch op, a, b, setcc, id into internal registers, update last-served, go EXEC.
REQ-018 alu_op/alu_a/alu_b SHALL be driven only from latched registers (zero when not in EXEC); requester inputs never reach the ALU combinationally.
REQ-019 EXEC: lasts exactly one cycle; at its end alu_res/alu_ovf/alu_zero SHALL be captured into rsp_res/rsp_ovf/rsp_zero, rsp_valid set, go RESP.
REQ-020 Latency: rsp_valid SHALL rise exactly 2 cycles after the accepting edge; throughput max one op per 3 cycles.
REQ-021 RESP: rsp_* SHALL hold stable while rsp_valid & !rsp_ready; on rsp_ready go IDLE and clear rsp_valid the next cycle.
REQ-022 rsp_ready high before rsp_valid SHALL have no effect.
REQ-023 Inputs changing while not accepted SHALL not affect any state.
REQ-024 Arithmetic: results are WIDTH-bit two's complement wrap-around; ovf SHALL come from the ALU unmodified (0 for AND/XOR).
REQ-025 Condition codes SHALL update on the EXEC-to-RESP edge only when latched setcc=1: zf=alu_zero, sf=alu_res[WIDTH-1], of=alu_ovf.

Reset
REQ-026 rst SHALL force IDLE, req0 priority, rsp_valid=0, rsp_id=0, rsp_res=0, rsp_ovf=0, rsp_zero=0, cc_zf=1, cc_sf=0, cc_of=0, alu_* = 0, reqN_ready=0 in that cycle.
REQ-027 rst in EXEC or RESP SHALL discard the in-flight operation; no response, no CC update.
REQ-028 rst SHALL dominate every simultaneous handshake.

Configuration
REQ-029 Macro ALU_SCHED_CC_EN defined: condition-code register present per REQ-025/026.
REQ-030 ALU_SCHED_CC_EN undefined: no CC storage; cc_zf, cc_sf, cc_of SHALL be constant 0, reqN_setcc ignored; all other behaviour identical.

Verification
REQ-031 req0 ADD a=5,b=7 alone -> accepted, rsp_valid 2 cycles later, rsp_res=12, rsp_id=0, ovf=0, zero=0.
REQ-032 Both valid from reset, req0 SUB 9-9, req1 XOR F0^0F, rsp_ready=1 -> req0 first (res 0, zero=1), then req1 (res FF, id=1).
REQ-033 req0 ADD 0x7FFF_FFFF_FFFF_FFFF+1, setcc=1 -> res 0x8000_0000_0000_0000, ovf=1, cc_of=1, cc_sf=1, cc_zf=0 (cc all 0 without ALU_SCHED_CC_EN).
REQ-034 rsp_ready held low 5 cycles in RESP -> rsp_* stable, reqN_ready low throughout; release -> IDLE next cycle.
REQ-035 rst asserted in EXEC of req1 AND 3&3 setcc=1 -> no rsp_valid, cc_zf=1, next grant goes to req0.
